fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 48 ++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction word, opcode field, HALT encoding and fetch FSM encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [5:0]  opcode_t;

   localparam opcode_t OP_HALT         = 6'b11_1111;
   localparam word_t   PC_INIT_DEFAULT = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t FETCH     = 2'd0;
   localparam fetch_state_t HOLD      = 2'd1;
   localparam fetch_state_t HALT_PEND = 2'd2;
   localparam fetch_state_t HALTED    = 2'd3;

   function automatic opcode_t opcode_of(input word_t w);
      return w[31:26];
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry fetch output buffer; a word leaves when valid and the decoder is ready.
module fetch_buffer
   import cpu_types_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  load_i,
   input  logic  flush_i,
   input  word_t instr_i,
   input  word_t pc_i,
   input  logic  dec_ready_i,
   output word_t instr_o,
   output word_t pc_o,
   output word_t npc_o,
   output logic  valid_o,
   output logic  transfer_o
);

   word_t instr_q, pc_q, npc_q;
   logic  valid_q;

   assign transfer_o = valid_q & dec_ready_i;

   // Load beats a same-cycle transfer so back-to-back words stream without a bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instr_q <= '0;
         pc_q    <= '0;
         npc_q   <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         npc_q   <= pc_i + 32'd4;
         valid_q <= 1'b1;
      end else if (transfer_o) begin
         valid_q <= 1'b0;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign npc_o   = npc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives imem requests, stalls on decoder backpressure,
// handles redirects and stops on a HALT word once the decoder has taken it.
//
// state     | meaning
// FETCH     | imemREN high, capturing words on ihit
// HOLD      | buffer full and decoder stalled; no request
// HALT_PEND | HALT word captured, waiting for it to transfer
// HALTED    | halted; only reset leaves
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  ihit,
   input  word_t imemload,
   output logic  imemREN,
   output word_t imemaddr,
   input  logic  redirect,
   input  word_t redirect_pc,
   input  logic  dec_ready,
   output word_t instr,
   output logic  instr_valid,
   output word_t pc,
   output word_t npc,
   output logic  halted
);

   fetch_state_t state_q, state_d;
   word_t        fpc_q, fpc_d;
   logic         halted_q, halted_d;
   logic         load, flush, transfer;

   always_comb begin
      state_d  = state_q;
      fpc_d    = fpc_q;
      halted_d = halted_q;
      load     = 1'b0;
      flush    = 1'b0;
      if (redirect && state_q != HALTED) begin
         flush   = 1'b1;
         fpc_d   = redirect_pc & 32'hFFFF_FFFC;
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (ihit) begin
                  if (instr_valid && !dec_ready) begin
                     state_d = HOLD;
                  end else begin
                     load  = 1'b1;
                     fpc_d = fpc_q + 32'd4;
                     if (opcode_of(imemload) == OP_HALT) state_d = HALT_PEND;
                  end
               end
            end
            HOLD: if (transfer) state_d = FETCH;
            HALT_PEND: begin
               if (transfer) begin
                  halted_d = 1'b1;
                  state_d  = HALTED;
               end
            end
            HALTED: ;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= FETCH;
         fpc_q    <= PC_INIT;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         halted_q <= halted_d;
      end
   end

   // Gate with nRST so no request is visible while reset is held.
   assign imemREN  = nRST & (state_q == FETCH);
   assign imemaddr = fpc_q & 32'hFFFF_FFFC;
   assign halted   = halted_q;

   fetch_buffer u_buf (
      .clk_i       (CLK),
      .rst_ni      (nRST),
      .load_i      (load),
      .flush_i     (flush),
      .instr_i     (imemload),
      .pc_i        (fpc_q),
      .dec_ready_i (dec_ready),
      .instr_o     (instr),
      .pc_o        (pc),
      .npc_o       (npc),
      .valid_o     (instr_valid),
      .transfer_o  (transfer)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, halt, flushed halt, reset and wrap.
module tb_fetch_unit;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  nRST, ihit, imemREN, redirect, dec_ready, instr_valid, halted;
   word_t imemload, imemaddr, redirect_pc, instr, pc, npc;
   word_t halt_addr;
   int    n_checks = 0;
   int    n_errors = 0;

   always #5 CLK = ~CLK;

   // Memory model: HALT word at halt_addr, otherwise opcode 2 tagged with the address.
   assign imemload = (imemaddr == halt_addr) ? 32'hFC00_0000 : {6'h02, imemaddr[25:0]};

   fetch_unit dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .imemload    (imemload),
      .imemREN     (imemREN),
      .imemaddr    (imemaddr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dec_ready   (dec_ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .npc         (npc),
      .halted      (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   function automatic word_t wd(input word_t a);
      return {6'h02, a[25:0]};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},   instr_valid, 0);
      check({tag, "_ren"},     imemREN,     0);
      check({tag, "_instr"},   instr,       0);
      check({tag, "_pc"},      pc,          0);
      check({tag, "_npc"},     npc,         0);
      check({tag, "_halted"},  halted,      0);
      check({tag, "_addr"},    imemaddr,    0);
   endtask

   initial begin
      nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; redirect_pc = '0;
      dec_ready = 1'b1; halt_addr = 32'h0000_0100;
      #1;
      check_reset_outputs("rst0");
      cyc(); cyc();
      nRST = 1'b1;
      #1;
      check("rel_ren", imemREN, 1);
      check("rel_addr", imemaddr, 0);

      // Sequential fetch
      ihit = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("seq_valid", instr_valid, 1);
         check("seq_pc", pc, 4 * i);
         check("seq_npc", npc, 4 * i + 4);
         check("seq_instr", instr, wd(4 * i));
      end

      // Stall while pc=8 is valid
      dec_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_ren", imemREN, 0);
         check("stall_pc", pc, 8);
         check("stall_instr", instr, wd(8));
         check("stall_valid", instr_valid, 1);
         check("stall_fpc", imemaddr, 12);
      end
      dec_ready = 1'b1;
      cyc();
      check("unstall_ren", imemREN, 1);
      check("unstall_addr", imemaddr, 12);
      check("unstall_valid", instr_valid, 0);
      cyc();
      check("resume_pc", pc, 12);
      check("resume_valid", instr_valid, 1);

      // Redirect with same-cycle ihit
      redirect = 1'b1; redirect_pc = 32'h0000_0043;
      cyc();
      redirect = 1'b0;
      check("redir_valid", instr_valid, 0);
      check("redir_addr", imemaddr, 32'h40);
      cyc();
      check("redir_pc", pc, 32'h40);
      check("redir_instr", instr, wd(32'h40));

      // Flushed halt
      halt_addr = 32'h10;
      redirect = 1'b1; redirect_pc = 32'h10;
      cyc();
      redirect = 1'b0; dec_ready = 1'b0;
      cyc();
      check("fh_instr", instr, 32'hFC00_0000);
      check("fh_pc", pc, 32'h10);
      check("fh_ren", imemREN, 0);
      cyc();
      check("fh_pend_ren", imemREN, 0);
      check("fh_pend_halted", halted, 0);
      redirect = 1'b1; redirect_pc = 32'h20; dec_ready = 1'b1;
      cyc();
      redirect = 1'b0;
      check("fh_halted", halted, 0);
      check("fh_valid", instr_valid, 0);
      check("fh_addr", imemaddr, 32'h20);
      check("fh_ren2", imemREN, 1);
      cyc();
      check("fh_resume_pc", pc, 32'h20);

      // Halt that transfers
      redirect = 1'b1; redirect_pc = 32'h10; dec_ready = 1'b0;
      cyc();
      redirect = 1'b0;
      cyc();
      check("h_instr", instr, 32'hFC00_0000);
      check("h_ren", imemREN, 0);
      check("h_halted_pre", halted, 0);
      cyc();
      check("h_halted_wait", halted, 0);
      dec_ready = 1'b1;
      cyc();
      check("h_halted", halted, 1);
      check("h_ren2", imemREN, 0);
      check("h_valid", instr_valid, 0);
      redirect = 1'b1; redirect_pc = 32'h40;
      cyc();
      redirect = 1'b0;
      check("h_redir_halted", halted, 1);
      check("h_redir_ren", imemREN, 0);
      cyc();
      check("h_redir_ren2", imemREN, 0);

      // Reset mid-stall
      halt_addr = 32'h0000_0100;
      nRST = 1'b0;
      #1;
      check_reset_outputs("rst1");
      cyc();
      nRST = 1'b1;
      #1;
      cyc(); cyc();
      dec_ready = 1'b0;
      cyc();
      check("rs_ren", imemREN, 0);
      check("rs_pc", pc, 4);
      nRST = 1'b0;
      #1;
      check_reset_outputs("rst2");
      cyc(); cyc();
      nRST = 1'b1; dec_ready = 1'b1;
      #1;
      check("rs_rel_addr", imemaddr, 0);
      check("rs_rel_ren", imemREN, 1);
      cyc();
      check("rs_first_pc", pc, 0);

      // Wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
      cyc();
      redirect = 1'b0;
      check("wrap_addr0", imemaddr, 32'hFFFF_FFF8);
      cyc();
      check("wrap_addr1", imemaddr, 32'hFFFF_FFFC);
      cyc();
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_npc", npc, 32'h0);
      check("wrap_instr", instr, 32'h0BFF_FFFC);
      check("wrap_addr2", imemaddr, 32'h0);
      cyc();
      check("wrap_pc0", pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
